// File: rtl/dmem_wait_ctrl.sv
// ============================================================================
// dmem_wait_ctrl: slow data RAM with programmable wait states and stall handshake.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (misaligned-access detection). Rev 1.0
// ============================================================================
`default_nettype none

module dmem_wait_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        done,
    output logic        align_err
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    is_wr_q, is_wr_d;
    logic                    mis_q, mis_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [31:0]             mem_q [DEPTH];

    logic                    w_req;
    logic                    w_mis_in;
    logic                    w_stall;
    logic                    w_commit;
    logic [ADDR_WIDTH-1:0]   w_c_idx;
    logic [31:0]             w_c_wdata;
    logic                    w_c_wr;
    logic                    w_c_mis;
    logic                    w_unused;

    assign w_req    = mem_read | mem_write;
    assign w_unused = ^{address[31:ADDR_WIDTH+2], address[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_mis_in  = (address[1:0] != 2'b00);
    assign align_err = (state_q == S_DONE) & mis_q;
`else
    assign w_mis_in  = 1'b0;
    assign align_err = 1'b0;
`endif

    // With zero wait states the commit happens on the accepting edge, so the
    // commit operands come straight from the inputs instead of the latches.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        is_wr_d   = is_wr_q;
        mis_d     = mis_q;
        w_stall   = 1'b0;
        w_commit  = 1'b0;
        w_c_idx   = idx_q;
        w_c_wdata = wdata_q;
        w_c_wr    = is_wr_q;
        w_c_mis   = mis_q;
        case (state_q)
            S_IDLE: begin
                if (w_req) begin
                    w_stall = 1'b1;
                    idx_d   = address[ADDR_WIDTH+1:2];
                    wdata_d = write_data;
                    is_wr_d = mem_write;
                    mis_d   = w_mis_in;
                    cnt_d   = WS;
                    if (WS == 4'd0) begin
                        state_d   = S_DONE;
                        w_commit  = 1'b1;
                        w_c_idx   = address[ADDR_WIDTH+1:2];
                        w_c_wdata = write_data;
                        w_c_wr    = mem_write;
                        w_c_mis   = w_mis_in;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_stall = 1'b1;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d  = S_DONE;
                    w_commit = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (w_commit && !w_c_wr) begin
            rdata_d = w_c_mis ? 32'h0 : mem_q[w_c_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            is_wr_q <= 1'b0;
            mis_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            mis_q   <= mis_d;
            rdata_q <= rdata_d;
        end
    end

    // Array has no reset; a reset edge suppresses any pending commit.
    always_ff @(posedge clk) begin
        if (rst_n && w_commit && w_c_wr && !w_c_mis) begin
            mem_q[w_c_idx] <= w_c_wdata;
        end
    end

    assign read_data = rdata_q;
    assign stall     = rst_n & w_stall;
    assign done      = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_dmem_wait_ctrl.sv
// ============================================================================
// tb_dmem_wait_ctrl: three instances (0, 2, 3 wait states) against a transaction model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dmem_wait_ctrl;

    logic        clk;
    logic        rst  [3];
    logic        mr   [3];
    logic        mw   [3];
    logic [31:0] ad   [3];
    logic [31:0] wd   [3];
    logic [31:0] rdo  [3];
    logic        st   [3];
    logic        dn   [3];
    logic        ae   [3];

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mdl   [3][256];
    bit          known [3][256];
    logic [31:0] rdm   [3];
    bit          rdk   [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_wait_ctrl #(
            .ADDR_WIDTH  (8),
            .WAIT_STATES ((g == 0) ? 0 : (g == 1) ? 2 : 3)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst[g]),
            .mem_read   (mr[g]),
            .mem_write  (mw[g]),
            .address    (ad[g]),
            .write_data (wd[g]),
            .read_data  (rdo[g]),
            .stall      (st[g]),
            .done       (dn[g]),
            .align_err  (ae[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 2 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_quiet(input int k);
        check($sformatf("idle_stall%0d", k), 32'(st[k]), 32'd0);
        check($sformatf("idle_done%0d", k), 32'(dn[k]), 32'd0);
        check($sformatf("idle_align%0d", k), 32'(ae[k]), 32'd0);
        if (rdk[k]) check($sformatf("idle_rdata%0d", k), rdo[k], rdm[k]);
    endtask

    task automatic idle(input int k, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            mr[k] = 1'b0;
            mw[k] = 1'b0;
            #1;
            check_quiet(k);
        end
    endtask

    // One complete access: request cycle, WAIT cycles, DONE cycle (request held).
    task automatic access(input int k, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] d, input bit noisy);
        int n;
        int idx;
        bit mis;
        n   = ws_of(k);
        idx = int'(a[9:2]);
`ifdef DMEM_ALIGN_CHECK_EN
        mis = (a[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        for (int c = 0; c <= n + 1; c++) begin
            @(negedge clk);
            if (noisy && c > 0 && c <= n) begin
                mr[k] = 1'($urandom);
                mw[k] = 1'($urandom);
                ad[k] = $urandom;
                wd[k] = $urandom;
            end else begin
                mr[k] = rd;
                mw[k] = wr;
                ad[k] = a;
                wd[k] = d;
            end
            if (c == n + 1) begin
                if (wr) begin
                    if (!mis) begin
                        mdl[k][idx]   = d;
                        known[k][idx] = 1'b1;
                    end
                end else if (mis) begin
                    rdm[k] = 32'h0;
                    rdk[k] = 1'b1;
                end else begin
                    rdm[k] = mdl[k][idx];
                    rdk[k] = known[k][idx];
                end
            end
            #1;
            check($sformatf("stall%0d_c%0d", k, c), 32'(st[k]), 32'(c <= n));
            check($sformatf("done%0d_c%0d", k, c), 32'(dn[k]), 32'(c == n + 1));
            check($sformatf("align%0d_c%0d", k, c), 32'(ae[k]), 32'((c == n + 1) && mis));
            if (rdk[k]) check($sformatf("rdata%0d_c%0d", k, c), rdo[k], rdm[k]);
        end
    endtask

    task automatic random_ops(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            int op;
            logic [31:0] a;
            op = $urandom_range(0, 3);
            a  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom);
            access(k, (op == 0) || (op == 3), op != 0, a, $urandom, 1'b1);
        end
        idle(k, 1);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b0; mr[k] = 1'b0; mw[k] = 1'b0; ad[k] = '0; wd[k] = '0;
            rdm[k] = 32'h0; rdk[k] = 1'b1;
            for (int j = 0; j < 256; j++) begin
                mdl[k][j] = '0;
                known[k][j] = 1'b0;
            end
        end
        mr[0] = 1'b1;
        mw[1] = 1'b1;

        // Reset held two cycles with requests present: stall must stay low.
        repeat (2) begin
            @(negedge clk);
            #1;
            check("rst_stall0", 32'(st[0]), 32'd0);
            check("rst_stall1", 32'(st[1]), 32'd0);
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; mr[k] = 1'b0; mw[k] = 1'b0;
        end
        #1;
        for (int k = 0; k < 3; k++) check_quiet(k);
        idle(1, 2);

        // WAIT_STATES=2: write then read.
        access(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        access(1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        idle(1, 1);

        // Aliasing and read/write priority.
        access(1, 1'b0, 1'b1, 32'h400, 32'h12345678, 1'b0);
        access(1, 1'b1, 1'b0, 32'h000, 32'h0, 1'b0);
        access(1, 1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, 1'b0);
        access(1, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
        idle(1, 1);

        // Alignment behaviour (expectation depends on build).
        access(1, 1'b0, 1'b1, 32'h20, 32'h55AA55AA, 1'b0);
        access(1, 1'b0, 1'b1, 32'h22, 32'h0BADF00D, 1'b0);
        access(1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        access(1, 1'b1, 1'b0, 32'h21, 32'h0, 1'b0);
        idle(1, 1);

        // Zero wait states: back-to-back reads.
        access(0, 1'b0, 1'b1, 32'h0, 32'h01020304, 1'b0);
        access(0, 1'b0, 1'b1, 32'h4, 32'hF0E0D0C0, 1'b0);
        idle(0, 1);
        access(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        access(0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        idle(0, 1);

        // Reset during the second WAIT cycle discards the write.
        access(2, 1'b0, 1'b1, 32'h20, 32'h11111111, 1'b0);
        access(2, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        @(negedge clk);
        mr[2] = 1'b0; mw[2] = 1'b1; ad[2] = 32'h20; wd[2] = 32'hCAFEF00D;
        #1;
        check("mid_stall_req", 32'(st[2]), 32'd1);
        @(negedge clk);
        #1;
        check("mid_stall_w1", 32'(st[2]), 32'd1);
        @(negedge clk);
        rst[2] = 1'b0;
        #1;
        check("mid_stall_rst", 32'(st[2]), 32'd0);
        @(negedge clk);
        rst[2] = 1'b1; mw[2] = 1'b0;
        rdm[2] = 32'h0; rdk[2] = 1'b1;
        #1;
        check_quiet(2);
        access(2, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        idle(2, 1);

        random_ops(1, 40);
        random_ops(0, 40);
        random_ops(2, 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
